sdram_arbiter: RTL



---
 rtl/sdram_arbiter.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM port between the audio loader, the recorder and the player, one word at a time.
// Optional build macro SDRAM_ARB_RR_EN: round-robin arbitration instead of fixed play > rec > load.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | arbitrate; latch winner, addr and wdata
// S_REFRESH | one-cycle refresh strobe before a non-sequential access
// S_ISSUE   | command held until finished or timeout down-counter expires
// S_DONE    | owner's done pulse; requests not sampled
module sdram_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init_mode,
  input  logic              i_load_req,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_wdata,
  output logic              o_load_done,
  input  logic              i_rec_req,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [DATA_W-1:0] i_rec_wdata,
  output logic              o_rec_done,
  input  logic              i_play_req,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [DATA_W-1:0] o_play_rdata,
  output logic              o_play_done,
  output logic              o_sdram_write,
  output logic              o_sdram_read,
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic [DATA_W-1:0] o_sdram_writedata,
  input  logic [DATA_W-1:0] i_sdram_readdata,
  input  logic              i_sdram_finished,
  output logic              o_sdram_refresh,
  output logic [1:0]        o_grant,
  output logic              o_timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_LOAD = 2'd1;
  localparam logic [1:0] OWN_REC  = 2'd2;
  localparam logic [1:0] OWN_PLAY = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REFRESH = 2'd1,
    S_ISSUE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write;
  logic                r_read;
  logic                r_refresh;
  logic [1:0]          r_grant;
  logic                r_load_done;
  logic                r_rec_done;
  logic                r_play_done;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_prev_valid;
  logic [1:0]          r_prev_owner;
  logic [ADDR_W-1:0]   r_prev_addr;
`ifdef SDRAM_ARB_RR_EN
  logic [1:0]          r_last;
`endif

  logic [1:0]          w_win;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic [ADDR_W-1:0]   w_prev_addr_inc;
  logic                w_seq;

  always_comb begin
    w_win = OWN_NONE;
    if (i_init_mode) begin
      w_win = i_load_req ? OWN_LOAD : OWN_NONE;
    end else begin
`ifdef SDRAM_ARB_RR_EN
      // search starts just after the last winner: load -> rec -> play -> load
      case (r_last)
        OWN_LOAD: begin
          if (i_rec_req)       w_win = OWN_REC;
          else if (i_play_req) w_win = OWN_PLAY;
          else if (i_load_req) w_win = OWN_LOAD;
        end
        OWN_REC: begin
          if (i_play_req)      w_win = OWN_PLAY;
          else if (i_load_req) w_win = OWN_LOAD;
          else if (i_rec_req)  w_win = OWN_REC;
        end
        default: begin
          if (i_load_req)      w_win = OWN_LOAD;
          else if (i_rec_req)  w_win = OWN_REC;
          else if (i_play_req) w_win = OWN_PLAY;
        end
      endcase
`else
      if (i_play_req)      w_win = OWN_PLAY;
      else if (i_rec_req)  w_win = OWN_REC;
      else if (i_load_req) w_win = OWN_LOAD;
`endif
    end
  end

  always_comb begin
    w_win_addr  = '0;
    w_win_wdata = '0;
    case (w_win)
      OWN_LOAD: begin
        w_win_addr  = i_load_addr;
        w_win_wdata = i_load_wdata;
      end
      OWN_REC: begin
        w_win_addr  = i_rec_addr;
        w_win_wdata = i_rec_wdata;
      end
      OWN_PLAY: w_win_addr = i_play_addr;
      default: ;
    endcase
  end

  // Increment wraps naturally at ADDR_W bits, so the top word followed by 0 counts as sequential.
  assign w_prev_addr_inc = r_prev_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_seq = r_prev_valid && (w_win == r_prev_owner) && (w_win_addr == w_prev_addr_inc);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_NONE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_refresh    <= 1'b0;
      r_grant      <= OWN_NONE;
      r_load_done  <= 1'b0;
      r_rec_done   <= 1'b0;
      r_play_done  <= 1'b0;
      r_rdata      <= '0;
      r_timeout    <= 1'b0;
      r_cnt        <= '0;
      r_prev_valid <= 1'b0;
      r_prev_owner <= OWN_NONE;
      r_prev_addr  <= '0;
`ifdef SDRAM_ARB_RR_EN
      r_last       <= OWN_PLAY;
`endif
    end else begin
      r_refresh   <= 1'b0;
      r_load_done <= 1'b0;
      r_rec_done  <= 1'b0;
      r_play_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_grant <= w_win;
          if (w_win != OWN_NONE) begin
            r_owner <= w_win;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
`ifdef SDRAM_ARB_RR_EN
            r_last  <= w_win;
`endif
            if (w_seq) begin
              r_state <= S_ISSUE;
              r_write <= (w_win != OWN_PLAY);
              r_read  <= (w_win == OWN_PLAY);
              r_cnt   <= CNT_LOAD;
            end else begin
              r_state   <= S_REFRESH;
              r_refresh <= 1'b1;
            end
          end
        end
        S_REFRESH: begin
          r_state <= S_ISSUE;
          r_write <= (r_owner != OWN_PLAY);
          r_read  <= (r_owner == OWN_PLAY);
          r_cnt   <= CNT_LOAD;
        end
        S_ISSUE: begin
          // finished wins over an expiring counter in the same cycle
          if (i_sdram_finished) begin
            r_state      <= S_DONE;
            r_write      <= 1'b0;
            r_read       <= 1'b0;
            r_grant      <= OWN_NONE;
            r_load_done  <= (r_owner == OWN_LOAD);
            r_rec_done   <= (r_owner == OWN_REC);
            r_play_done  <= (r_owner == OWN_PLAY);
            r_prev_valid <= 1'b1;
            r_prev_owner <= r_owner;
            r_prev_addr  <= r_addr;
            if (r_owner == OWN_PLAY) r_rdata <= i_sdram_readdata;
          end else if (r_cnt == '0) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_read       <= 1'b0;
            r_grant      <= OWN_NONE;
            r_timeout    <= 1'b1;
            r_load_done  <= (r_owner == OWN_LOAD);
            r_rec_done   <= (r_owner == OWN_REC);
            r_play_done  <= (r_owner == OWN_PLAY);
            r_prev_valid <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_load_done       = r_load_done;
  assign o_rec_done        = r_rec_done;
  assign o_play_done       = r_play_done;
  assign o_play_rdata      = r_rdata;
  assign o_sdram_write     = r_write;
  assign o_sdram_read      = r_read;
  assign o_sdram_addr      = r_addr;
  assign o_sdram_writedata = r_wdata;
  assign o_sdram_refresh   = r_refresh;
  assign o_grant           = r_grant;
  assign o_timeout         = r_timeout;

endmodule
